tetris_input_ctrl: RTL
======================

TETRIS_INPUT_CTRL -- requirements
Module: tetris_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the stable cycles needed before a debounced level changes (10 ms at 50 MHz).
REQ-002 SHALL have parameter DAS_DELAY, default 8000000, meaning the cycles from press to the first auto-repeat.
REQ-003 SHALL have parameter DAS_PERIOD, default 2500000, meaning the cycles between subsequent auto-repeats.
REQ-004 SHALL have port clock, input, 1 bit: the single clock, 50 MHz system clock; all flops on its posedge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_raw, input, 8 bits, unsynchronized joystick pins: [0] up, [1] right, [2] down, [3] left, [4] rotate-L, [5] rotate-R, [6] hold, [7] game-reset; each active-high.
REQ-007 SHALL have port key_ack, input, 1 bit: CPU read strobe that consumes the pending event.
REQ-008 SHALL have port key_valid, output, 1 bit: an event is pending.
REQ-009 SHALL have port key_code, output, 4 bits: the pending event code, or 0 when none is pending.
REQ-010 SHALL have port btn_level, output, 8 bits: the debounced button levels.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag set when an event is dropped.

Function
REQ-012 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other logic.
REQ-013 SHALL keep one debounce counter per button; counter clears whenever the synchronized bit equals btn_level; btn_level bit toggles when the synchronized bit has differed for DEBOUNCE_CYCLES consecutive cycles; counter then clears.
REQ-014 SHALL generate a press event on each 0->1 transition of a btn_level bit; 1->0 transitions generate nothing.
REQ-015 SHALL map event codes as: up=1, right=2, down=3, left=4, rotate-L=7, rotate-R=8, hold=9, game-reset=10.
REQ-016 SHALL resolve simultaneous events (presses and repeats in the same cycle) by selecting the highest code; all others are dropped.
REQ-017 SHALL load the selected event into key_code and set key_valid on the cycle after the btn_level edge, giving a total latency of 2 + DEBOUNCE_CYCLES + 1 cycles from a stable raw press.
REQ-018 SHALL, when key_ack=1 and key_valid=1, clear key_valid and set key_code to 0 on the next edge.
REQ-019 SHALL ignore key_ack when key_valid=0.
REQ-020 SHALL, when an event arrives while key_valid=1 and key_ack=0, drop the new event, keep key_code unchanged, and set overflow.
REQ-021 SHALL, when an event arrives in the same cycle as a consuming key_ack, load the new event; key_valid stays 1 and no overflow is raised.
REQ-022 SHALL clear overflow on a consuming key_ack.
REQ-023 SHALL implement an auto-repeat FSM with states IDLE, DELAY and REPEAT, plus registers rep_key (2 bits: right/down/left) and rep_cnt.
REQ-024 SHALL, in any state, on a press of right, down or left, set rep_key to that key (highest code if several), clear rep_cnt, and go to DELAY.
REQ-025 SHALL, in DELAY, increment rep_cnt; when rep_cnt reaches DAS_DELAY-1, emit a repeat event with rep_key's code, clear rep_cnt, and go to REPEAT.
REQ-026 SHALL, in REPEAT, emit a repeat event every DAS_PERIOD cycles.
REQ-027 SHALL, in DELAY or REPEAT, go to IDLE on the cycle btn_level of rep_key falls, regardless of other held keys, and emit no event in that cycle.
REQ-028 SHALL never auto-repeat up, rotate-L, rotate-R, hold or game-reset; these keys do not affect the FSM.
REQ-029 SHALL size rep_cnt and the debounce counters to hold the largest parameter value without wrap-around.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear: synchronizers, debounce counters, btn_level=0, key_valid=0, key_code=0, overflow=0, FSM=IDLE, rep_key=0, rep_cnt=0.
REQ-031 SHALL treat a button held through reset release as a fresh press after debounce.
REQ-032 SHALL lose any pending event when reset is asserted mid-operation.

Verification (DEBOUNCE_CYCLES=4, DAS_DELAY=10, DAS_PERIOD=3)
REQ-033 SHALL test single press: raw hold=1 held steady -> key_valid=1, key_code=9 exactly 7 cycles after the first sampling edge; ack -> key_code=0 next cycle.
REQ-034 SHALL test bounce rejection: raw up toggles every 2 cycles for 20 cycles then stays 0 -> no event, btn_level[0]=0 throughout.
REQ-035 SHALL test auto-repeat: left held with ack pulsed whenever valid -> events of code 4 at press, +10 cycles, then every 3 cycles; release -> no further events.
REQ-036 SHALL test priority and overflow: right and rotate-R rise in the same cycle -> key_code=8; an un-acked down press afterwards -> key_code stays 8, overflow=1; ack -> overflow=0.
REQ-037 SHALL test ack collision: an event arriving on the same edge as ack -> new code is loaded, key_valid stays 1, overflow=0.
REQ-038 SHALL test reset mid-REPEAT: reset=0 while left is held -> all outputs 0 immediately; after release of reset with left still held -> new press event at debounce latency.

Source files
------------

// File: rtl/tetris_input_ctrl.sv
// Joystick front end: synchronizes and debounces eight buttons, turns presses into a
// one-deep event register for the CPU, and auto-repeats the right/down/left keys.
module tetris_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DAS_DELAY       = 8000000,
  parameter int unsigned DAS_PERIOD      = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] btn_raw,
  input  logic       key_ack,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] btn_level,
  output logic       overflow
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax = (DAS_DELAY > DAS_PERIOD) ? DAS_DELAY : DAS_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] DelayLast  = RepW'(DAS_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'(DAS_PERIOD - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDelay  = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;

  logic [7:0]     sync1_q, sync2_q;
  logic [DbW-1:0] db_cnt_q [8];
  logic [DbW-1:0] db_cnt_d [8];
  logic [7:0]     level_q, level_d, level_prev_q;
  logic [7:0]     press;

  logic [1:0]      state_q, state_d;
  logic [1:0]      rep_key_q, rep_key_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic [2:0]      rep_idx;
  logic            rep_held;
  logic            rep_fire;
  logic [3:0]      rep_code;

  logic [3:0] press_code, rep_ev, event_code;
  logic       event_valid, consume;
  logic       key_valid_q, key_valid_d;
  logic [3:0] key_code_q, key_code_d;
  logic       overflow_q, overflow_d;

  function automatic logic [3:0] btn_code(input logic [2:0] idx);
    logic [3:0] code;
    case (idx)
      3'd0:    code = 4'd1;
      3'd1:    code = 4'd2;
      3'd2:    code = 4'd3;
      3'd3:    code = 4'd4;
      3'd4:    code = 4'd7;
      3'd5:    code = 4'd8;
      3'd6:    code = 4'd9;
      default: code = 4'd10;
    endcase
    return code;
  endfunction

  // Counter only runs while the synchronized bit disagrees with the debounced level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 8; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = level_q & ~level_prev_q;

  // Codes rise with bit index, so the last hit in an ascending scan is the highest.
  always_comb begin
    press_code = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (press[i]) press_code = btn_code(3'(i));
    end
  end

  // rep_key 0/1/2 = right/down/left, i.e. button index rep_key+1 and code rep_key+2.
  assign rep_idx  = {1'b0, rep_key_q} + 3'd1;
  assign rep_held = level_q[rep_idx];
  assign rep_code = {2'b00, rep_key_q} + 4'd2;

  always_comb begin
    state_d   = state_q;
    rep_key_d = rep_key_q;
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    case (state_q)
      StDelay, StRepeat: begin
        if (!rep_held) begin
          state_d   = StIdle;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == ((state_q == StDelay) ? DelayLast : PeriodLast)) begin
          rep_fire  = 1'b1;
          rep_cnt_d = '0;
          state_d   = StRepeat;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      StIdle:  ;
      default: state_d = StIdle;
    endcase
    if (|press[3:1]) begin
      state_d   = StDelay;
      rep_cnt_d = '0;
      rep_key_d = press[3] ? 2'd2 : (press[2] ? 2'd1 : 2'd0);
    end
  end

  assign rep_ev      = rep_fire ? rep_code : 4'd0;
  assign event_code  = (rep_ev > press_code) ? rep_ev : press_code;
  assign event_valid = (event_code != 4'd0);
  assign consume     = key_ack & key_valid_q;

  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overflow_d  = overflow_q;
    if (consume) begin
      key_valid_d = 1'b0;
      key_code_d  = 4'd0;
      overflow_d  = 1'b0;
    end
    if (event_valid) begin
      if (!key_valid_q || consume) begin
        key_valid_d = 1'b1;
        key_code_d  = event_code;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
      state_q      <= StIdle;
      rep_key_q    <= '0;
      rep_cnt_q    <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 4'd0;
      overflow_q   <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q      <= state_d;
      rep_key_q    <= rep_key_d;
      rep_cnt_q    <= rep_cnt_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      overflow_q   <= overflow_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign btn_level = level_q;
  assign overflow  = overflow_q;

endmodule
